// File: rtl/arccos_pkg.sv
// rtl/arccos_pkg.sv - shared states, constants and helpers for the BCD arccos path
package arccos_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SEARCH,
    ROUND,
    MAP,
    BCD,
    DONE
  } state_t;

  localparam int ANGLE_MAX  = 90;
  localparam int ANGLE_W    = 8;
  localparam int MAG_W      = 7;
  localparam int ROM_DEPTH  = 91;
  localparam int BCD_SHIFTS = 8;

  function automatic logic [MAG_W-1:0] absdiff(input logic [MAG_W-1:0] a,
                                               input logic [MAG_W-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [12+ANGLE_W-1:0] dabble_step(input logic [12+ANGLE_W-1:0] s);
    logic [12+ANGLE_W-1:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (r[ANGLE_W+4*i +: 4] >= 4'd5)
        r[ANGLE_W+4*i +: 4] = r[ANGLE_W+4*i +: 4] + 4'd3;
    end
    return {r[12+ANGLE_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/cos_rom.sv
// rtl/cos_rom.sv - combinational round(100*cos(a deg)) table, a = 0..90
module cos_rom
  import arccos_pkg::*;
(
  input  logic [6:0]       addr,
  output logic [MAG_W-1:0] data
);

  always_comb begin
    data = '0;
    case (addr)
      7'd0:  data = 7'd100; 7'd1:  data = 7'd100; 7'd2:  data = 7'd100; 7'd3:  data = 7'd100; 7'd4:  data = 7'd100;
      7'd5:  data = 7'd100; 7'd6:  data = 7'd99;  7'd7:  data = 7'd99;  7'd8:  data = 7'd99;  7'd9:  data = 7'd99;
      7'd10: data = 7'd98;  7'd11: data = 7'd98;  7'd12: data = 7'd98;  7'd13: data = 7'd97;  7'd14: data = 7'd97;
      7'd15: data = 7'd97;  7'd16: data = 7'd96;  7'd17: data = 7'd96;  7'd18: data = 7'd95;  7'd19: data = 7'd95;
      7'd20: data = 7'd94;  7'd21: data = 7'd93;  7'd22: data = 7'd93;  7'd23: data = 7'd92;  7'd24: data = 7'd91;
      7'd25: data = 7'd91;  7'd26: data = 7'd90;  7'd27: data = 7'd89;  7'd28: data = 7'd88;  7'd29: data = 7'd87;
      7'd30: data = 7'd87;  7'd31: data = 7'd86;  7'd32: data = 7'd85;  7'd33: data = 7'd84;  7'd34: data = 7'd83;
      7'd35: data = 7'd82;  7'd36: data = 7'd81;  7'd37: data = 7'd80;  7'd38: data = 7'd79;  7'd39: data = 7'd78;
      7'd40: data = 7'd77;  7'd41: data = 7'd75;  7'd42: data = 7'd74;  7'd43: data = 7'd73;  7'd44: data = 7'd72;
      7'd45: data = 7'd71;  7'd46: data = 7'd69;  7'd47: data = 7'd68;  7'd48: data = 7'd67;  7'd49: data = 7'd66;
      7'd50: data = 7'd64;  7'd51: data = 7'd63;  7'd52: data = 7'd62;  7'd53: data = 7'd60;  7'd54: data = 7'd59;
      7'd55: data = 7'd57;  7'd56: data = 7'd56;  7'd57: data = 7'd54;  7'd58: data = 7'd53;  7'd59: data = 7'd52;
      7'd60: data = 7'd50;  7'd61: data = 7'd48;  7'd62: data = 7'd47;  7'd63: data = 7'd45;  7'd64: data = 7'd44;
      7'd65: data = 7'd42;  7'd66: data = 7'd41;  7'd67: data = 7'd39;  7'd68: data = 7'd37;  7'd69: data = 7'd36;
      7'd70: data = 7'd34;  7'd71: data = 7'd33;  7'd72: data = 7'd31;  7'd73: data = 7'd29;  7'd74: data = 7'd28;
      7'd75: data = 7'd26;  7'd76: data = 7'd24;  7'd77: data = 7'd22;  7'd78: data = 7'd21;  7'd79: data = 7'd19;
      7'd80: data = 7'd17;  7'd81: data = 7'd16;  7'd82: data = 7'd14;  7'd83: data = 7'd12;  7'd84: data = 7'd10;
      7'd85: data = 7'd9;   7'd86: data = 7'd7;   7'd87: data = 7'd5;   7'd88: data = 7'd3;   7'd89: data = 7'd2;
      7'd90: data = 7'd0;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/arccos_bcd.sv
// rtl/arccos_bcd.sv - signed BCD cosine (x100) to BCD angle 0..180 deg
// Define ARCCOS_NEAREST_EN to round the search result to the nearest table angle.
module arccos_bcd
  import arccos_pkg::*;
#(
  parameter int ITER        = 7,
  parameter bit HOLD_RESULT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sign,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] ang_ones,
  output logic [3:0] ang_tens,
  output logic [3:0] ang_hundreds
);

  state_t state, state_next;

  logic                   sign_q;
  logic [3:0]             h_q, t_q, o_q;
  logic                   err_q;
  logic [MAG_W-1:0]       mag_q;
  logic [6:0]             lo, hi, mid;
  logic [4:0]             cnt;
  logic [12+ANGLE_W-1:0]  shreg;
  logic                   in_err;
  logic [MAG_W-1:0]       mag_calc;
  logic [MAG_W-1:0]       rom_data;
  logic [ANGLE_W-1:0]     angle;

  assign in_err = (h_q > 4'd9) || (t_q > 4'd9) || (o_q > 4'd9) || (h_q > 4'd1) ||
                  ((h_q == 4'd1) && ((t_q != 4'd0) || (o_q != 4'd0)));
  assign mag_calc = MAG_W'(h_q) * 7'd100 + MAG_W'(t_q) * 7'd10 + MAG_W'(o_q);
  assign mid      = 7'(({1'b0, lo} + {1'b0, hi}) >> 1);
  assign angle    = sign_q ? (8'd180 - {1'b0, lo}) : {1'b0, lo};

  // Once the search has converged lo == hi, so mid also addresses rom[lo].
  cos_rom u_rom (
    .addr (mid),
    .data (rom_data)
  );

`ifdef ARCCOS_NEAREST_EN
  logic [MAG_W-1:0] rom_prev;

  cos_rom u_rom_prev (
    .addr (lo - 7'd1),
    .data (rom_prev)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:   if (start) state_next = CHECK;
      CHECK:  state_next = in_err ? DONE : SEARCH;
      SEARCH: begin
        if (cnt == 5'(ITER - 1)) begin
`ifdef ARCCOS_NEAREST_EN
          state_next = ROUND;
`else
          state_next = MAP;
`endif
        end
      end
      ROUND:  state_next = MAP;
      MAP:    state_next = BCD;
      BCD:    if (cnt == 5'(BCD_SHIFTS - 1)) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q       <= 1'b0;
      h_q          <= '0;
      t_q          <= '0;
      o_q          <= '0;
      err_q        <= 1'b0;
      mag_q        <= '0;
      lo           <= '0;
      hi           <= '0;
      cnt          <= '0;
      shreg        <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      ang_ones     <= '0;
      ang_tens     <= '0;
      ang_hundreds <= '0;
    end else begin
      done <= 1'b0;
      if (!HOLD_RESULT && done) begin
        error        <= 1'b0;
        ang_ones     <= '0;
        ang_tens     <= '0;
        ang_hundreds <= '0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            sign_q <= sign;
            h_q    <= hundreds;
            t_q    <= tens;
            o_q    <= ones;
            error  <= 1'b0;
          end
        end
        CHECK: begin
          err_q <= in_err;
          mag_q <= mag_calc;
          lo    <= '0;
          hi    <= 7'(ANGLE_MAX);
          cnt   <= '0;
        end
        SEARCH: begin
          cnt <= cnt + 5'd1;
          if (rom_data <= mag_q) hi <= mid;
          else                   lo <= mid + 7'd1;
        end
`ifdef ARCCOS_NEAREST_EN
        ROUND: begin
          if ((lo != 7'd0) && (absdiff(rom_prev, mag_q) <= absdiff(rom_data, mag_q)))
            lo <= lo - 7'd1;
        end
`endif
        MAP: begin
          shreg <= {12'd0, angle};
          cnt   <= '0;
        end
        BCD: begin
          shreg <= dabble_step(shreg);
          cnt   <= cnt + 5'd1;
        end
        DONE: begin
          done  <= 1'b1;
          error <= err_q;
          if (err_q) begin
            ang_hundreds <= '0;
            ang_tens     <= '0;
            ang_ones     <= '0;
          end else begin
            ang_hundreds <= shreg[ANGLE_W+8 +: 4];
            ang_tens     <= shreg[ANGLE_W+4 +: 4];
            ang_ones     <= shreg[ANGLE_W   +: 4];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arccos_bcd.sv
// tb/tb_arccos_bcd.sv - directed and swept checks of arccos_bcd (HOLD_RESULT 1 and 0)
module tb_arccos_bcd;

  logic       clk = 1'b0;
  logic       reset, start, sign;
  logic [3:0] ones, tens, hundreds;
  logic       busy, done, error;
  logic [3:0] ang_ones, ang_tens, ang_hundreds;
  logic       c_busy, c_done, c_error;
  logic [3:0] c_ones, c_tens, c_hundreds;

  int checks = 0;
  int errors = 0;
  int rom_ref [0:90];

`ifdef ARCCOS_NEAREST_EN
  localparam int LAT = 19;
  localparam int SIX_ANG = 86;
`else
  localparam int LAT = 18;
  localparam int SIX_ANG = 87;
`endif

  always #5 clk = ~clk;

  arccos_bcd #(.ITER(7), .HOLD_RESULT(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .sign(sign),
    .ones(ones), .tens(tens), .hundreds(hundreds),
    .busy(busy), .done(done), .error(error),
    .ang_ones(ang_ones), .ang_tens(ang_tens), .ang_hundreds(ang_hundreds)
  );

  arccos_bcd #(.ITER(7), .HOLD_RESULT(1'b0)) dut_clr (
    .clk(clk), .reset(reset), .start(start), .sign(sign),
    .ones(ones), .tens(tens), .hundreds(hundreds),
    .busy(c_busy), .done(c_done), .error(c_error),
    .ang_ones(c_ones), .ang_tens(c_tens), .ang_hundreds(c_hundreds)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_angle(input int s, input int mag);
    int a;
    a = 0;
    while (a < 90 && rom_ref[a] > mag) a++;
`ifdef ARCCOS_NEAREST_EN
    if (a > 0) begin
      int dp, dc;
      dp = rom_ref[a-1] - mag; if (dp < 0) dp = -dp;
      dc = rom_ref[a] - mag;   if (dc < 0) dc = -dc;
      if (dp <= dc) a--;
    end
`endif
    return (s != 0) ? 180 - a : a;
  endfunction

  task automatic run_op(input string tag, input logic s, input logic [3:0] h,
                        input logic [3:0] t, input logic [3:0] o,
                        input int exp_ang, input logic exp_err, input int exp_lat);
    int  edges;
    bit  seen;
    @(negedge clk);
    sign = s; hundreds = h; tens = t; ones = o; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_latency"}, edges, exp_lat);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_hundreds"}, ang_hundreds, exp_ang / 100);
    chk({tag, "_tens"}, ang_tens, (exp_ang / 10) % 10);
    chk({tag, "_ones"}, ang_ones, exp_ang % 10);
    chk({tag, "_clr_angle"}, {c_hundreds, c_tens, c_ones},
        {4'(exp_ang / 100), 4'((exp_ang / 10) % 10), 4'(exp_ang % 10)});
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_hold"}, {ang_hundreds, ang_tens, ang_ones},
        {4'(exp_ang / 100), 4'((exp_ang / 10) % 10), 4'(exp_ang % 10)});
    chk({tag, "_clr_after"}, {c_hundreds, c_tens, c_ones, 3'b000, c_error}, 16'h0);
  endtask

  initial begin
    int n_done;
    logic [11:0] got;
    for (int a = 0; a <= 90; a++)
      rom_ref[a] = $rtoi(100.0 * $cos(a * 3.14159265358979 / 180.0) + 0.5);

    reset = 1'b1; start = 1'b0; sign = 1'b0;
    ones = '0; tens = '0; hundreds = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_angle", {ang_hundreds, ang_tens, ang_ones}, 0);
    reset = 1'b0;

    run_op("full_scale", 1'b0, 4'd1, 4'd0, 4'd0, 0,   1'b0, LAT);
    run_op("half",       1'b0, 4'd0, 4'd5, 4'd0, 60,  1'b0, LAT);
    run_op("neg_half",   1'b1, 4'd0, 4'd5, 4'd0, 120, 1'b0, LAT);
    run_op("neg_zero",   1'b1, 4'd0, 4'd0, 4'd0, 90,  1'b0, LAT);
    run_op("six",        1'b0, 4'd0, 4'd0, 4'd6, SIX_ANG, 1'b0, LAT);
    run_op("bad_tens",   1'b0, 4'd0, 4'hA, 4'd0, 0,   1'b1, 2);
    run_op("bad_101",    1'b0, 4'd1, 4'd0, 4'd1, 0,   1'b1, 2);
    run_op("bad_hund",   1'b1, 4'd2, 4'd0, 4'd0, 0,   1'b1, 2);
    run_op("after_err",  1'b0, 4'd0, 4'd8, 4'd7, 29,  1'b0, LAT);

    // Start while busy and input changes after acceptance must not disturb the result.
    @(negedge clk);
    sign = 1'b0; hundreds = 4'd0; tens = 4'd5; ones = 4'd0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; sign = 1'b1; tens = 4'd0; ones = 4'd3;
    n_done = 0;
    got = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 4) start = 1'b1;
      if (i == 5) start = 1'b0;
      if (done) begin
        n_done++;
        got = {ang_hundreds, ang_tens, ang_ones};
      end
    end
    chk("repulse_done_count", n_done, 1);
    chk("repulse_angle", got, 12'h060);

    // Reset in the middle of the search aborts without a done pulse.
    @(negedge clk);
    sign = 1'b0; hundreds = 4'd0; tens = 4'd0; ones = 4'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_angle", {ang_hundreds, ang_tens, ang_ones}, 0);
    chk("midreset_clr_busy", c_busy, 0);
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n_done++;
    end
    chk("midreset_no_done", n_done, 0);
    run_op("post_reset", 1'b1, 4'd0, 4'd5, 4'd0, 120, 1'b0, LAT);

    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m <= 100; m++) begin
        run_op($sformatf("sweep_s%0d_m%0d", s, m), s[0], 4'(m / 100), 4'((m / 10) % 10),
               4'(m % 10), ref_angle(s, m), 1'b0, LAT);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
